decode_issue_ctrl: RTL and testbench
====================================

Name: decode_issue_ctrl

Overview:
- Sequences the decode stage's register-file read ports.
- Holds one fetched instruction, checks its source and destination registers against a 32-entry busy scoreboard, and stalls until all are free.
- Once clear, issues the instruction downstream with a valid/ready handshake.
- Sits between fetch and decode/execute; writeback releases busy bits.

Parameters:
- NUM_REGS, 32, number of architectural registers; index width is log2(NUM_REGS) = 5.
- ZERO_REG_HAZARD_FREE, 1, when 1, register 0 is never marked busy and never causes a stall.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  controller accepts an instruction this cycle.
- instruction  input  32  fetched instruction.
- in_wr_en  input  1  the instruction writes its destination register.
- out_valid  output  1  held instruction is hazard-free and offered downstream.
- out_ready  input  1  downstream consumes the instruction.
- instruction_out  output  32  held instruction.
- src1  output  5  instruction_out[19:15]; drives register-file read port 1.
- src2  output  5  instruction_out[14:10]; drives register-file read port 2.
- stall  output  1  an instruction is held but blocked by a hazard.
- wb_valid  input  1  a writeback completes this cycle.
- wb_reg  input  5  register released by the writeback.
- flush  input  1  discard the held instruction.

Behaviour:
- Fields: opcode [31:25], dst [24:20], src1 [19:15], src2 [14:10].
- States: EMPTY and HELD.
- Reset (synchronous): state=EMPTY; busy[*]=0; instruction_out=0; held wr_en=0.
  - Resulting outputs: out_valid=0, stall=0, src1=0, src2=0, in_ready=1.
  - Reset mid-operation drops the held instruction and all pending busy bits.
- Hazard condition:
  - busy[src1], busy[src2], or (held wr_en and busy[dst]).
  - A register equal to wb_reg while wb_valid=1 counts as free this cycle (same-cycle writeback bypass).
  - Register 0 is never busy when ZERO_REG_HAZARD_FREE=1.
- Output decodes:
  - out_valid = HELD and no hazard.
  - stall = HELD and hazard.
  - issue = out_valid and out_ready.
  - in_ready = EMPTY or issue (allows back-to-back issue).
- Transitions:
  - EMPTY + in_valid: capture instruction and in_wr_en → HELD.
  - HELD + issue, with in_valid: capture the new instruction, stay HELD.
  - HELD + issue, without in_valid: → EMPTY.
  - HELD + no issue: hold instruction_out stable; it must not change while out_valid=1 and out_ready=0.
- Latency: accepted instruction can be issued the next cycle; minimum 1 cycle accept→out_valid.
- Scoreboard updates:
  - On issue with held wr_en and dst≠0 (or any dst when ZERO_REG_HAZARD_FREE=0): set busy[dst].
  - wb_valid clears busy[wb_reg].
  - Set and clear of the same register in the same cycle: set wins, because the newer writer owns the register.
- flush (priority over everything except reset):
  - state → EMPTY, in_ready=0 that cycle.
  - No issue, no capture, no busy set that cycle.
  - Writeback clear still applies.
  - Scoreboard is not cleared; in-flight writes still retire.
- Multiple pending writers per register are impossible: a WAW hazard stalls until the writeback.
- src1/src2 follow instruction_out combinationally; the register file is read asynchronously by the consumer.

Optional Feature:
- Macro: DECODE_STALL_COUNT_EN.
- Defined:
  - Adds output stall_cycles [31:0], reset to 0.
  - Increments every cycle stall=1; wraps at 2^32.
  - Adds output issue_count [31:0], incremented on each issue.
- Undefined: no ports, no counters; behaviour otherwise identical.

Decomposition:
- Shared package decode_pkg holds:
  - field bit-position constants (OPC_MSB/LSB, DST_MSB/LSB, SRC1_MSB/LSB, SRC2_MSB/LSB);
  - REG_IDX_W=5;
  - state enum {ST_EMPTY, ST_HELD}.
- One sub-module: reg_scoreboard.
  - Busy vector with set/clear ports.
  - Three combinational lookup ports with wb bypass.
  - Set-wins rule.

Test Plan:
- Independent instructions: r1←r2+r3, then r4←r5+r6, out_ready=1 → issued on consecutive cycles, stall never 1, busy[1] and busy[4] set.
- RAW: issue r1←…, then r7←r1+r2 → stall=1 and out_valid=0 until wb_valid with wb_reg=1; out_valid=1 in that same cycle (bypass).
- WAW: r3←… pending, next instruction writes r3 → stalls until wb_reg=3; on issue, busy[3] is set again (set-wins when wb and issue coincide).
- Backpressure: out_ready=0 for 4 cycles with no hazard → out_valid held high, instruction_out stable, in_ready=0; issues on the 5th cycle.
- flush while HELD with a hazard → next cycle out_valid=0, in_ready=1; busy bits unchanged; a later wb still clears its bit.
- Reset asserted in HELD with busy[1]=1 → next cycle out_valid=0, busy all 0, instruction_out=0; with DECODE_STALL_COUNT_EN, stall_cycles=0.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: instruction field positions, register index width and issue FSM states
package decode_pkg;
  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 25;
  localparam int DST_MSB   = 24;
  localparam int DST_LSB   = 20;
  localparam int SRC1_MSB  = 19;
  localparam int SRC1_LSB  = 15;
  localparam int SRC2_MSB  = 14;
  localparam int SRC2_LSB  = 10;
  localparam int REG_IDX_W = 5;
  typedef enum logic {ST_EMPTY, ST_HELD} state_e;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register busy vector with set/clear and three bypassed lookup ports
//   clk, reset           : clock, synchronous active-high reset (clears all busy bits)
//   set_en/set_idx       : mark a register busy (a new writer has issued)
//   clr_en/clr_idx       : release a register (writeback); seen as free in the same cycle
//   idx_a/b/c -> busy_a/b/c : combinational busy lookups
module reg_scoreboard
  import decode_pkg::*;
#(
  parameter int NUM_REGS             = 32,
  parameter bit ZERO_REG_HAZARD_FREE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic [REG_IDX_W-1:0] idx_a,
  input  logic [REG_IDX_W-1:0] idx_b,
  input  logic [REG_IDX_W-1:0] idx_c,
  output logic                 busy_a,
  output logic                 busy_b,
  output logic                 busy_c
);
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                set_ok;
  function automatic logic lookup(logic [REG_IDX_W-1:0] idx);
    return busy_q[idx] && !(clr_en && clr_idx == idx) && !(ZERO_REG_HAZARD_FREE && idx == '0);
  endfunction
  assign busy_a = lookup(idx_a);
  assign busy_b = lookup(idx_b);
  assign busy_c = lookup(idx_c);
  assign set_ok = set_en && !(ZERO_REG_HAZARD_FREE && set_idx == '0);
  // Set applied after clear: the newly issued writer owns the register.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_ok) busy_d[set_idx] = 1'b1;
  end
  always_ff @(posedge clk) busy_q <= reset ? '0 : busy_d;
endmodule

// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: holds one fetched instruction, stalls on scoreboard hazards, issues via valid/ready
//   in_valid/in_ready/instruction/in_wr_en : fetch side
//   out_valid/out_ready/instruction_out    : downstream side; src1/src2 feed the register-file read ports
//   stall                                  : held instruction blocked by a busy register
//   wb_valid/wb_reg                        : writeback release; flush drops the held instruction
//   DECODE_STALL_COUNT_EN adds stall_cycles and issue_count counters
module decode_issue_ctrl
  import decode_pkg::*;
#(
  parameter int NUM_REGS             = 32,
  parameter bit ZERO_REG_HAZARD_FREE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instruction,
  input  logic                 in_wr_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          instruction_out,
  output logic [REG_IDX_W-1:0] src1,
  output logic [REG_IDX_W-1:0] src2,
  output logic                 stall,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_reg,
  input  logic                 flush
`ifdef DECODE_STALL_COUNT_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          issue_count
`endif
);
  state_e                 state_q, state_d;
  logic [31:0]            instr_q, instr_d;
  logic                   wr_q, wr_d;
  logic [REG_IDX_W-1:0]   dst;
  logic                   b1, b2, bd, hazard, issue, accept;
  assign dst             = instr_q[DST_MSB:DST_LSB];
  assign src1            = instr_q[SRC1_MSB:SRC1_LSB];
  assign src2            = instr_q[SRC2_MSB:SRC2_LSB];
  assign instruction_out = instr_q;
  reg_scoreboard #(
    .NUM_REGS            (NUM_REGS),
    .ZERO_REG_HAZARD_FREE(ZERO_REG_HAZARD_FREE)
  ) u_sb (
    .clk    (clk),
    .reset  (reset),
    .set_en (issue && wr_q),
    .set_idx(dst),
    .clr_en (wb_valid),
    .clr_idx(wb_reg),
    .idx_a  (src1),
    .idx_b  (src2),
    .idx_c  (dst),
    .busy_a (b1),
    .busy_b (b2),
    .busy_c (bd)
  );
  // Flush suppresses the offer as well as the capture so downstream never sees a handshake that is dropped.
  always_comb begin
    hazard    = b1 || b2 || (wr_q && bd);
    out_valid = state_q == ST_HELD && !hazard && !flush;
    stall     = state_q == ST_HELD && hazard;
    issue     = out_valid && out_ready;
    in_ready  = !flush && (state_q == ST_EMPTY || issue);
    accept    = in_valid && in_ready;
    state_d   = flush ? ST_EMPTY : accept ? ST_HELD : issue ? ST_EMPTY : state_q;
    instr_d   = accept ? instruction : instr_q;
    wr_d      = accept ? in_wr_en : wr_q;
  end
  always_ff @(posedge clk) begin
    state_q <= reset ? ST_EMPTY : state_d;
    instr_q <= reset ? '0 : instr_d;
    wr_q    <= reset ? 1'b0 : wr_d;
  end
`ifdef DECODE_STALL_COUNT_EN
  logic [31:0] stall_cnt_q, issue_cnt_q;
  always_ff @(posedge clk) begin
    stall_cnt_q <= reset ? '0 : stall_cnt_q + {31'd0, stall};
    issue_cnt_q <= reset ? '0 : issue_cnt_q + {31'd0, issue};
  end
  assign stall_cycles = stall_cnt_q;
  assign issue_count  = issue_cnt_q;
`endif
endmodule

// File: tb/tb_decode_issue_ctrl.sv
// tb_decode_issue_ctrl: directed scenarios plus randomized traffic checked against a behavioural model
module tb_decode_issue_ctrl;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, in_wr_en, out_valid, out_ready, stall, wb_valid, flush;
  logic [31:0] instruction, instruction_out;
  logic [4:0]  src1, src2, wb_reg;
`ifdef DECODE_STALL_COUNT_EN
  logic [31:0] stall_cycles, issue_count;
`endif
  int n_checks = 0, n_fail = 0;
  logic [31:0] m_busy, m_instr;
  bit          m_held, m_wr;
  int unsigned m_stalls, m_issues;

  always #5 clk = ~clk;

  decode_issue_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .in_wr_en(in_wr_en), .out_valid(out_valid), .out_ready(out_ready), .instruction_out(instruction_out),
    .src1(src1), .src2(src2), .stall(stall), .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush)
`ifdef DECODE_STALL_COUNT_EN
    , .stall_cycles(stall_cycles), .issue_count(issue_count)
`endif
  );

  function automatic logic [31:0] mk(int d, int s1, int s2);
    return {7'h33, 5'(d), 5'(s1), 5'(s2), 10'($urandom)};
  endfunction

  // A register blocks only if it is busy, not r0, and not being written back right now.
  function automatic bit eb(logic [4:0] r);
    return r != 5'd0 && m_busy[r] && !(wb_valid && wb_reg == r);
  endfunction
  function automatic bit e_stall();
    return m_held && (eb(m_instr[19:15]) || eb(m_instr[14:10]) || (m_wr && eb(m_instr[24:20])));
  endfunction
  function automatic bit e_ov();
    return m_held && !e_stall() && !flush;
  endfunction
  function automatic bit e_ir();
    return !flush && (!m_held || (e_ov() && out_ready));
  endfunction

  task automatic idle();
    reset = 0; in_valid = 0; in_wr_en = 0; instruction = '0; out_ready = 0;
    wb_valid = 0; wb_reg = '0; flush = 0;
  endtask

  task automatic tick();
    bit iss, acc;
    iss = e_ov() && out_ready;
    acc = in_valid && e_ir();
    if (reset) begin
      m_busy = '0; m_held = 0; m_wr = 0; m_instr = '0; m_stalls = 0; m_issues = 0;
    end else begin
      m_stalls += 32'(e_stall());
      m_issues += 32'(iss);
      if (wb_valid) m_busy[wb_reg] = 1'b0;
      if (iss && m_wr && m_instr[24:20] != 5'd0) m_busy[m_instr[24:20]] = 1'b1;
      if (flush) m_held = 0;
      else if (acc) begin m_held = 1; m_instr = instruction; m_wr = in_wr_en; end
      else if (iss) m_held = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); reset = 1; tick(); reset = 0;
  endtask

  task automatic test_reset();
    do_reset(); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if ({src1, src2} !== 10'd0) begin n_fail++; $display("FAIL reset_src: got %h/%h expected 0/0", src1, src2); end
    n_checks++; if (instruction_out !== 32'd0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", instruction_out); end
    n_checks++; if (dut.u_sb.busy_q !== 32'd0) begin n_fail++; $display("FAIL reset_busy: got %h expected 0", dut.u_sb.busy_q); end
  endtask

  task automatic test_independent();
    logic [31:0] a, b;
    a = mk(1, 2, 3); b = mk(4, 5, 6);
    do_reset();
    in_valid = 1; instruction = a; in_wr_en = 1; out_ready = 1; tick();
    instruction = b; #1;
    n_checks++; if ({out_valid, stall, in_ready} !== 3'b101) begin n_fail++; $display("FAIL indep_first: got ov/st/ir=%b expected 101", {out_valid, stall, in_ready}); end
    n_checks++; if (instruction_out !== a) begin n_fail++; $display("FAIL indep_first_instr: got %h expected %h", instruction_out, a); end
    tick(); in_valid = 0; #1;
    n_checks++; if ({out_valid, stall} !== 2'b10) begin n_fail++; $display("FAIL indep_second: got ov/st=%b expected 10", {out_valid, stall}); end
    n_checks++; if ({instruction_out, src1, src2} !== {b, 5'd5, 5'd6}) begin n_fail++; $display("FAIL indep_second_instr: got %h %0d %0d expected %h 5 6", instruction_out, src1, src2, b); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL indep_drain: got %b expected 0", out_valid); end
    n_checks++; if (dut.u_sb.busy_q !== 32'h12) begin n_fail++; $display("FAIL indep_busy: got %h expected 12", dut.u_sb.busy_q); end
  endtask

  task automatic test_raw();
    do_reset();
    in_valid = 1; instruction = mk(1, 2, 3); in_wr_en = 1; out_ready = 1; tick();
    instruction = mk(7, 1, 2); tick();
    in_valid = 0; #1;
    n_checks++; if ({out_valid, stall, in_ready} !== 3'b010) begin n_fail++; $display("FAIL raw_stall: got ov/st/ir=%b expected 010", {out_valid, stall, in_ready}); end
    tick();
    n_checks++; if ({out_valid, stall} !== 2'b01) begin n_fail++; $display("FAIL raw_stall_hold: got ov/st=%b expected 01", {out_valid, stall}); end
    wb_valid = 1; wb_reg = 5'd1; #1;
    n_checks++; if ({out_valid, stall} !== 2'b10) begin n_fail++; $display("FAIL raw_bypass: got ov/st=%b expected 10", {out_valid, stall}); end
    tick(); wb_valid = 0;
    n_checks++; if (dut.u_sb.busy_q !== 32'h80) begin n_fail++; $display("FAIL raw_busy: got %h expected 80", dut.u_sb.busy_q); end
  endtask

  task automatic test_waw();
    do_reset();
    in_valid = 1; instruction = mk(3, 0, 0); in_wr_en = 1; out_ready = 1; tick();
    instruction = mk(3, 4, 5); tick();
    in_valid = 0; #1;
    n_checks++; if ({out_valid, stall} !== 2'b01) begin n_fail++; $display("FAIL waw_stall: got ov/st=%b expected 01", {out_valid, stall}); end
    tick();
    wb_valid = 1; wb_reg = 5'd3; #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL waw_bypass: got %b expected 1", out_valid); end
    tick(); wb_valid = 0;
    n_checks++; if (dut.u_sb.busy_q !== 32'h8) begin n_fail++; $display("FAIL waw_set_wins: got %h expected 8", dut.u_sb.busy_q); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b;
    a = mk(8, 9, 10); b = mk(11, 12, 13);
    do_reset();
    in_valid = 1; instruction = a; in_wr_en = 0; out_ready = 0; tick();
    instruction = b;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if ({out_valid, in_ready, instruction_out} !== {2'b10, a}) begin n_fail++; $display("FAIL bp_hold%0d: got ov/ir=%b instr=%h expected 10 %h", i, {out_valid, in_ready}, instruction_out, a); end
      tick();
    end
    out_ready = 1; #1;
    n_checks++; if ({out_valid, in_ready} !== 2'b11) begin n_fail++; $display("FAIL bp_release: got ov/ir=%b expected 11", {out_valid, in_ready}); end
    tick(); in_valid = 0; #1;
    n_checks++; if ({out_valid, instruction_out} !== {1'b1, b}) begin n_fail++; $display("FAIL bp_next: got ov=%b instr=%h expected 1 %h", out_valid, instruction_out, b); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1; instruction = mk(1, 0, 0); in_wr_en = 1; out_ready = 1; tick();
    instruction = mk(2, 1, 0); tick();
    instruction = mk(9, 9, 9); flush = 1; #1;
    n_checks++; if ({out_valid, in_ready, stall} !== 3'b001) begin n_fail++; $display("FAIL flush_cycle: got ov/ir/st=%b expected 001", {out_valid, in_ready, stall}); end
    tick(); flush = 0; in_valid = 0; #1;
    n_checks++; if ({out_valid, in_ready, stall} !== 3'b010) begin n_fail++; $display("FAIL flush_after: got ov/ir/st=%b expected 010", {out_valid, in_ready, stall}); end
    n_checks++; if (dut.u_sb.busy_q !== 32'h2) begin n_fail++; $display("FAIL flush_busy_kept: got %h expected 2", dut.u_sb.busy_q); end
    wb_valid = 1; wb_reg = 5'd1; tick(); wb_valid = 0;
    n_checks++; if (dut.u_sb.busy_q !== 32'h0) begin n_fail++; $display("FAIL flush_wb_clear: got %h expected 0", dut.u_sb.busy_q); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1; instruction = mk(1, 0, 0); in_wr_en = 1; out_ready = 1; tick();
    instruction = mk(5, 1, 1); tick();
    in_valid = 0; tick();
    reset = 1; tick(); reset = 0; #1;
    n_checks++; if ({out_valid, stall, in_ready} !== 3'b001) begin n_fail++; $display("FAIL rstmid_out: got ov/st/ir=%b expected 001", {out_valid, stall, in_ready}); end
    n_checks++; if ({instruction_out, dut.u_sb.busy_q} !== 64'd0) begin n_fail++; $display("FAIL rstmid_state: got instr=%h busy=%h expected 0 0", instruction_out, dut.u_sb.busy_q); end
`ifdef DECODE_STALL_COUNT_EN
    n_checks++; if ({stall_cycles, issue_count} !== 64'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d/%0d expected 0/0", stall_cycles, issue_count); end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      reset       = $urandom_range(0, 99) == 0;
      flush       = $urandom_range(0, 19) == 0;
      in_valid    = $urandom_range(0, 2) != 0;
      in_wr_en    = $urandom_range(0, 1) == 1;
      instruction = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      out_ready   = $urandom_range(0, 3) != 0;
      wb_valid    = $urandom_range(0, 1) == 1;
      wb_reg      = 5'($urandom_range(0, 7));
      #1;
      n_checks++; if ({out_valid, stall, in_ready} !== {e_ov(), e_stall(), e_ir()}) begin n_fail++; $display("FAIL rnd_ctrl@%0d: got ov/st/ir=%b expected %b", i, {out_valid, stall, in_ready}, {e_ov(), e_stall(), e_ir()}); end
      n_checks++; if ({instruction_out, src1, src2} !== {m_instr, m_instr[19:15], m_instr[14:10]}) begin n_fail++; $display("FAIL rnd_instr@%0d: got %h expected %h", i, instruction_out, m_instr); end
      n_checks++; if (dut.u_sb.busy_q !== m_busy) begin n_fail++; $display("FAIL rnd_busy@%0d: got %h expected %h", i, dut.u_sb.busy_q, m_busy); end
`ifdef DECODE_STALL_COUNT_EN
      n_checks++; if ({stall_cycles, issue_count} !== {m_stalls, m_issues}) begin n_fail++; $display("FAIL rnd_cnt@%0d: got %0d/%0d expected %0d/%0d", i, stall_cycles, issue_count, m_stalls, m_issues); end
`endif
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    m_busy = '0; m_instr = '0; m_held = 0; m_wr = 0; m_stalls = 0; m_issues = 0;
    test_reset();
    test_independent();
    test_raw();
    test_waw();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
